// File: rtl/mas_acc_seq.sv
// mas_acc_seq: sequential modular add/subtract accumulator, IDLE/ACC/DONE.
// Ports: clk, rst_n, start, cfg_q, cfg_len, busy, in_valid/in_ready/in_op/in_data,
//   out_valid/out_ready/out_data/out_err. Option: MAS_ACC_RANGE_CHK_EN.
module mas_acc_seq #(
  parameter int LEN_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       cfg_q,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [4:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic             out_err
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       acc, acc_nxt;
  logic [4:0]       q;
  logic [LEN_W-1:0] cnt;
  logic             xfer;

  logic signed [5:0] sacc, sd, sq, t;

  assign xfer = (state == ACC) && in_valid;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ACC;
      ACC:     if (xfer && cnt == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // 6-bit signed sum, then a single conditional wrap by Q
  always_comb begin
    sacc = $signed({2'b00, acc});
    sd   = $signed({in_data[4], in_data});
    sq   = $signed({q[4], q});
    t    = in_op ? (sacc - sd) : (sacc + sd);
    if (t < 0)        acc_nxt = 4'(t + sq);
    else if (t >= sq) acc_nxt = 4'(t - sq);
    else              acc_nxt = 4'(t);
  end

`ifdef MAS_ACC_RANGE_CHK_EN
  logic err;
  logic op_bad;

  assign op_bad = (sd < 0) || (sd >= sq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (state == IDLE && start) begin
      // Q must lie in [1,15]; as a signed 5-bit value that is simply Q > 0
      err <= ($signed(cfg_q) <= 0);
    end else if (xfer && op_bad) begin
      err <= 1'b1;
    end
  end

  assign out_err = (state == DONE) ? err : 1'b0;
`else
  logic op_bad;

  assign op_bad  = 1'b0;
  assign out_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      q     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        q   <= cfg_q;
        cnt <= cfg_len;
        acc <= '0;
      end else if (xfer) begin
        // illegal operands still decrement the count but leave acc alone
        if (!op_bad) acc <= acc_nxt;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign out_data  = (state == DONE) ? acc : 4'd0;

endmodule

// File: tb/tb_mas_acc_seq.sv
// tb_mas_acc_seq: directed self-checking bench for mas_acc_seq.
// Drives inputs 1 ns after the rising edge and samples there too.
module tb_mas_acc_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] cfg_q = '0;
  logic [2:0] cfg_len = '0;
  logic       busy;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_op = 1'b0;
  logic [4:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic       out_err;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mas_acc_seq #(.LEN_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_q(cfg_q), .cfg_len(cfg_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [4:0] q, input logic [2:0] len);
    start = 1'b1;
    cfg_q = q;
    cfg_len = len;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_rdy", in_ready, 1);
  endtask

  task automatic send(input logic op, input logic [4:0] d);
    int n;
    n = 0;
    in_op = op;
    in_data = d;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_rdy", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic get(input string tag,
                     input logic [3:0] ed,
                     input logic ee);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_ov"}, out_valid, 1);
    check({tag, "_d"}, out_data, ed);
    check({tag, "_e"}, out_err, ee);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, busy, 0);
    check({tag, "_ov0"}, out_valid, 0);
  endtask

  initial begin
    // reset state
    #2;
    check("rst_busy", busy, 0);
    check("rst_rdy", in_ready, 0);
    check("rst_ov", out_valid, 0);
    check("rst_od", out_data, 0);
    check("rst_oe", out_err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // in_valid in IDLE is ignored
    in_valid = 1'b1;
    tick();
    check("idle_rdy", in_ready, 0);
    check("idle_busy2", busy, 0);
    in_valid = 1'b0;

    // Q=7: +5 +4 -6 -> 3
    do_start(5'd7, 3'd2);
    send(1'b0, 5'd5);
    send(1'b0, 5'd4);
    check("t1_ov_pre", out_valid, 0);
    send(1'b1, 5'd6);
    check("t1_ov_lat", out_valid, 1);
    get("t1", 4'd3, 1'b0);

    // Q=15: +14 +14 -> 13
    do_start(5'd15, 3'd1);
    send(1'b0, 5'd14);
    send(1'b0, 5'd14);
    get("t2", 4'd13, 1'b0);

    // Q=13: +12 +5 -3 +9 -> 10, with gaps and stray starts
    do_start(5'd13, 3'd3);
    send(1'b0, 5'd12);
    start = 1'b1;
    cfg_q = 5'd3;
    cfg_len = 3'd0;
    tick();
    check("t3_gap_busy", busy, 1);
    check("t3_gap_ov", out_valid, 0);
    tick();
    start = 1'b0;
    send(1'b0, 5'd5);
    tick();
    send(1'b1, 5'd3);
    start = 1'b1;
    send(1'b0, 5'd9);
    in_valid = 1'b1;
    in_data = 5'd1;
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_ov", out_valid, 1);
      check("t3_hold_d", out_data, 10);
      check("t3_hold_rdy", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    check("t3_ov", out_valid, 1);
    check("t3_d", out_data, 10);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    check("t3_exit_busy", busy, 0);
    tick();
    check("t3_exit_busy2", busy, 0);

    // Q=5: +6 +3
    do_start(5'd5, 3'd1);
    send(1'b0, 5'd6);
    send(1'b0, 5'd3);
`ifdef MAS_ACC_RANGE_CHK_EN
    get("t4", 4'd3, 1'b1);
    do_start(5'd5, 3'd0);
    send(1'b0, 5'd2);
    get("t4b", 4'd2, 1'b0);
`else
    get("t4", 4'd4, 1'b0);
`endif

    // reset mid-sequence
    do_start(5'd7, 3'd3);
    send(1'b0, 5'd3);
    send(1'b0, 5'd3);
    rst_n = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_rdy", in_ready, 0);
    check("t5_ov", out_valid, 0);
    check("t5_od", out_data, 0);
    check("t5_oe", out_err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_idle", busy, 0);
    check("t5_noout", out_valid, 0);
    do_start(5'd7, 3'd0);
    send(1'b0, 5'd2);
    get("t5", 4'd2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
